rf_write_arbiter: RTL and testbench

Write-port arbiter for the 32 x 32-bit register file (two combinational read ports, one clocked write port). It shares the single write port between two writeback sources: the pipeline ALU writeback (port 0) and the multi-cycle load/mul unit (port 1). Accepted writes go through a one-stage registered output that drives the register file's write-enable, address and data. Port 1 has a starvation guard, and an optional forwarding path covers the one cycle in which a granted write is not yet visible in the file.

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rf_bypass_mux.sv | 18 +
 rtl/rf_write_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths, arbiter state enum and zero-register constant
package rf_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam int unsigned ZERO_REG = 0;

   typedef enum logic {
      NORMAL  = 1'b0,
      STARVED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rf_bypass_mux.sv
// rtl/rf_bypass_mux.sv - forwards the pending write-stage data over raw register-file read data
module rf_bypass_mux
   import rf_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] fwd_data
);

   assign fwd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : rf_data;

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-source register-file write arbiter with starvation guard
// Optional read forwarding enabled by macro RF_ARB_BYPASS_EN.
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
`ifdef RF_ARB_BYPASS_EN
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   input  logic [DATA_W-1:0] rf_data1,
   input  logic [DATA_W-1:0] rf_data2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
`endif
   output logic              starved
);

   localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   arb_state_e        state;
   logic [3:0]        wait_cnt;
   logic [3:0]        wait_cnt_nxt;
   logic              grant0;
   logic              grant1;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Readies are gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         if (state == STARVED)
            grant1 = req1_valid;
         else if (req0_valid)
            grant0 = 1'b1;
         else
            grant1 = req1_valid;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign sel_addr   = grant1 ? req1_addr : req0_addr;
   assign sel_data   = grant1 ? req1_data : req0_data;

   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (grant1 || !req1_valid)
         wait_cnt_nxt = 4'd0;
      else if (wait_cnt != 4'hF)
         wait_cnt_nxt = wait_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= NORMAL;
         wait_cnt <= 4'd0;
         starved  <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         if (wait_cnt_nxt >= LIMIT) begin
            state   <= STARVED;
            starved <= 1'b1;
         end else begin
            state   <= NORMAL;
            starved <= 1'b0;
         end
         // Register 0 writes are consumed but never reach the file.
         if (grant0 || grant1) begin
            wr_en   <= (sel_addr != ZERO_ADDR);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end else begin
            wr_en   <= 1'b0;
         end
      end
   end

`ifdef RF_ARB_BYPASS_EN
   rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass1 (
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr1),
      .rf_data  (rf_data1),
      .fwd_data (fwd_data1)
   );

   rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass2 (
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr2),
      .rf_data  (rf_data2),
      .fwd_data (fwd_data2)
   );
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter (RF_ARB_BYPASS_EN optional)
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        starved;
`ifdef RF_ARB_BYPASS_EN
   logic [4:0]  rd_addr1, rd_addr2;
   logic [31:0] rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif

   logic [31:0] rf [32] = '{default: 32'h0};
   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   // Register-file model fed from the write stage
   always @(posedge clk)
      if (wr_en) rf[wr_addr] <= wr_data;

   rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
`ifdef RF_ARB_BYPASS_EN
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rf_data1   (rf_data1),
      .rf_data2   (rf_data2),
      .fwd_data1  (fwd_data1),
      .fwd_data2  (fwd_data2),
`endif
      .starved    (starved)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
`ifdef RF_ARB_BYPASS_EN
      rd_addr1 = 5'd0; rd_addr2 = 5'd0; rf_data1 = 32'h0; rf_data2 = 32'h0;
`endif
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0: got %b want 0", req0_ready); else pass_cnt++;
      total_cnt++; if (req1_ready !== 1'b0) $display("FAIL reset_ready1: got %b want 0", req1_ready); else pass_cnt++;
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (wr_addr !== 5'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); else pass_cnt++;
      total_cnt++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else pass_cnt++;
      total_cnt++; if (starved !== 1'b0) $display("FAIL reset_starved: got %b want 0", starved); else pass_cnt++;
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h12345678;
      #1;
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_ready0: got %b want 1", req0_ready); else pass_cnt++;
      total_cnt++; if (req1_ready !== 1'b0) $display("FAIL single_ready1: got %b want 0", req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL single_wr_en: got %b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (wr_addr !== 5'd3) $display("FAIL single_wr_addr: got %0d want 3", wr_addr); else pass_cnt++;
      total_cnt++; if (wr_data !== 32'h12345678) $display("FAIL single_wr_data: got %h want 12345678", wr_data); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL single_wr_en_drop: got %b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (wr_addr !== 5'd3) $display("FAIL single_addr_hold: got %0d want 3", wr_addr); else pass_cnt++;
      total_cnt++; if (rf[3] !== 32'h12345678) $display("FAIL single_rf3: got %h want 12345678", rf[3]); else pass_cnt++;
   endtask

   task automatic test_priority();
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hA;
      req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hB;
      #1;
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL prio_ready0: got %b want 1", req0_ready); else pass_cnt++;
      total_cnt++; if (req1_ready !== 1'b0) $display("FAIL prio_ready1_lose: got %b want 0", req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      #1;
      total_cnt++; if (wr_addr !== 5'd4) $display("FAIL prio_addr_first: got %0d want 4", wr_addr); else pass_cnt++;
      total_cnt++; if (wr_data !== 32'hA) $display("FAIL prio_data_first: got %h want a", wr_data); else pass_cnt++;
      total_cnt++; if (req1_ready !== 1'b1) $display("FAIL prio_ready1_next: got %b want 1", req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      total_cnt++; if (wr_addr !== 5'd6) $display("FAIL prio_addr_second: got %0d want 6", wr_addr); else pass_cnt++;
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL prio_wr_en_second: got %b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (wr_data !== 32'hB) $display("FAIL prio_data_second: got %h want b", wr_data); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_starvation();
      logic exp_r0, exp_r1, exp_st;
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h100;
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
      for (int c = 0; c < 6; c++) begin
         exp_r0 = (c != 4);
         exp_r1 = (c == 4);
         exp_st = (c == 4);
         #1;
         total_cnt++; if (req0_ready !== exp_r0) $display("FAIL starve_ready0_c%0d: got %b want %b", c, req0_ready, exp_r0); else pass_cnt++;
         total_cnt++; if (req1_ready !== exp_r1) $display("FAIL starve_ready1_c%0d: got %b want %b", c, req1_ready, exp_r1); else pass_cnt++;
         total_cnt++; if (starved !== exp_st) $display("FAIL starve_flag_c%0d: got %b want %b", c, starved, exp_st); else pass_cnt++;
         @(posedge clk); #1;
         if (c == 4) begin
            req1_valid = 1'b0;
            total_cnt++; if (wr_addr !== 5'd9) $display("FAIL starve_wr_addr: got %0d want 9", wr_addr); else pass_cnt++;
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
      #1;
      total_cnt++; if (req1_ready !== 1'b1) $display("FAIL zero_ready1: got %b want 1", req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      req1_addr = 5'd2; req1_data = 32'h22;
      #1;
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL zero_wr_en: got %b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (req1_ready !== 1'b1) $display("FAIL zero_next_ready1: got %b want 1", req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL zero_next_wr_en: got %b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (wr_addr !== 5'd2) $display("FAIL zero_next_addr: got %0d want 2", wr_addr); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (rf[0] !== 32'h0) $display("FAIL zero_rf0: got %h want 0", rf[0]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req0_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req0_addr = 5'(10 + i); req0_data = 32'hC0 + 32'(i);
         #1;
         total_cnt++; if (req0_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, req0_ready); else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 5'(10 + i) || wr_data !== 32'hC0 + 32'(i))
            $display("FAIL b2b_write_%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", i, wr_en, wr_addr, wr_data, 10 + i, 32'hC0 + 32'(i));
         else pass_cnt++;
      end
      req0_valid = 1'b0;
      @(posedge clk); #1;
      total_cnt++; if (rf[12] !== 32'hC2) $display("FAIL b2b_rf12: got %h want c2", rf[12]); else pass_cnt++;
   endtask

`ifdef RF_ARB_BYPASS_EN
   task automatic test_bypass();
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h55;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      rd_addr1 = 5'd7; rf_data1 = 32'h11;
      rd_addr2 = 5'd8; rf_data2 = 32'h22;
      #1;
      total_cnt++; if (fwd_data1 !== 32'h55) $display("FAIL bypass_fwd1: got %h want 55", fwd_data1); else pass_cnt++;
      total_cnt++; if (fwd_data2 !== 32'h22) $display("FAIL bypass_fwd2: got %h want 22", fwd_data2); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (fwd_data1 !== 32'h11) $display("FAIL bypass_fwd1_idle: got %h want 11", fwd_data1); else pass_cnt++;
   endtask
`endif

   task automatic test_reset_mid_write();
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      @(posedge clk); #1;
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL midrst_pending: got %b want 1", wr_en); else pass_cnt++;
      #1;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (wr_data !== 32'h0) $display("FAIL midrst_wr_data: got %h want 0", wr_data); else pass_cnt++;
      total_cnt++; if (req0_ready !== 1'b0) $display("FAIL midrst_ready0: got %b want 0", req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (rf[5] !== 32'h0) $display("FAIL midrst_rf5: got %h want 0", rf[5]); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL postrst_ready0: got %b want 1", req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 5'd5) $display("FAIL postrst_write: got en=%b addr=%0d want en=1 addr=5", wr_en, wr_addr); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_priority();
      test_starvation();
      test_zero_reg();
      test_back_to_back();
`ifdef RF_ARB_BYPASS_EN
      test_bypass();
`endif
      test_reset_mid_write();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
